// File: rtl/onchip_ram_pipe.sv
// Single-port on-chip RAM behind a pipelined Avalon-MM slave, with a zero-fill engine run after reset.
// Latency: a read accepted at edge N presents readdatavalid/readdata after edge N+READ_LATENCY; writes land on the accept edge.
// Backpressure: waitrequest is high while clearing, while clken is low, and while in reset; clken low freezes the entire block.
//
// Ports:
//   clk, reset_n          single rising-edge clock, asynchronous active-low reset
//   address, byteenable   word address and write byte lanes
//   chipselect, read,     request qualifiers; read+write together performs only the write
//   write, writedata
//   clken                 global clock enable (hold everything when low)
//   readdata,             read return; readdata is meaningful only while readdatavalid is high
//   readdatavalid
//   waitrequest           no request is accepted while high
//   clear_busy            high while the zero-fill is sweeping the array
//   parity_err            (ONCHIP_RAM_PARITY_EN only) pulses with readdatavalid on a stored-parity mismatch
//
// Optional feature macro: ONCHIP_RAM_PARITY_EN adds one even-parity bit per byte lane to the array.

module onchip_ram_pipe #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 9,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic                  clken,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic                  clear_busy
`ifdef ONCHIP_RAM_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    // Only latencies of 1 and 2 are meaningful; anything else is treated as 1.
    localparam int LAT   = (READ_LATENCY == 2) ? 2 : 1;
`ifdef ONCHIP_RAM_PARITY_EN
    localparam int PAR_W = NB;
`else
    localparam int PAR_W = 0;
`endif
    localparam int MEM_W = DATA_W + PAR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    // ------------------------------------------------------------------
    // Storage: parity bits (when present) sit above the data bits.
    // ------------------------------------------------------------------
    logic [MEM_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              clr_last;

    logic              rd_acc;
    logic              wr_acc;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [NB-1:0]     mem_be;
    logic [DATA_W-1:0] mem_wdat;

    // Request stage: the accepted read address is registered first, the
    // array is read from that register on the following enabled edge.
    logic              rq_vld_q;
    logic [ADDR_W-1:0] rq_addr_q;
    logic [MEM_W-1:0]  rd_word;

    logic [LAT-1:0]    pipe_vld_q;
    logic [DATA_W-1:0] pipe_dat_q [LAT];

`ifdef ONCHIP_RAM_PARITY_EN
    logic [NB-1:0]     mem_wpar;
    logic              rd_perr;
    logic [LAT-1:0]    pipe_perr_q;
`endif

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        clr_last    = (clr_cnt_q == {ADDR_W{1'b1}});
        clear_busy  = (state_q == CLEAR);
        // Reset is folded in so nothing is accepted while reset is held,
        // even when the fill is disabled and the FSM resets straight to RUN.
        waitrequest = clear_busy | ~clken | ~reset_n;
        case (state_q)
            CLEAR:   if (clken && clr_last) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = RST_STATE;
        endcase
    end

    // A simultaneous read+write performs the write and drops the read.
    assign rd_acc = chipselect & read & ~write & ~waitrequest;
    assign wr_acc = chipselect & write & ~waitrequest;

    // ------------------------------------------------------------------
    // Array write port: shared between the zero-fill engine and the bus.
    // ------------------------------------------------------------------
    always_comb begin
        mem_we   = clken & reset_n & (clear_busy | wr_acc);
        mem_addr = address;
        mem_be   = byteenable;
        mem_wdat = writedata;
        if (clear_busy) begin
            mem_addr = clr_cnt_q;
            mem_be   = {NB{1'b1}};
            mem_wdat = '0;
        end
    end

`ifdef ONCHIP_RAM_PARITY_EN
    // Even parity: stored bit makes the lane's total count of ones even,
    // so an all-zero fill naturally stores parity 0.
    always_comb begin
        mem_wpar = '0;
        for (int b = 0; b < NB; b++) begin
            mem_wpar[b] = ^mem_wdat[b*8 +: 8];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b]) begin
                    mem[mem_addr][b*8 +: 8] <= mem_wdat[b*8 +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
                    mem[mem_addr][DATA_W + b] <= mem_wpar[b];
`endif
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Array read port.
    // ------------------------------------------------------------------
    assign rd_word = mem[rq_addr_q];

`ifdef ONCHIP_RAM_PARITY_EN
    always_comb begin
        rd_perr = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if ((^rd_word[b*8 +: 8]) != rd_word[DATA_W + b]) rd_perr = 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // State, clear counter and read pipeline; all frozen while clken is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RST_STATE;
            clr_cnt_q  <= '0;
            rq_vld_q   <= 1'b0;
            rq_addr_q  <= '0;
            pipe_vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_dat_q[i] <= '0;
            end
`ifdef ONCHIP_RAM_PARITY_EN
            pipe_perr_q <= '0;
`endif
        end else if (clken) begin
            state_q <= state_d;
            // Wraps back to 0 on the last fill write, ready for the next reset.
            if (clear_busy) clr_cnt_q <= clr_cnt_q + ADDR_W'(1);

            rq_vld_q <= rd_acc;
            if (rd_acc) rq_addr_q <= address;

            pipe_vld_q[0] <= rq_vld_q;
            if (rq_vld_q) pipe_dat_q[0] <= rd_word[DATA_W-1:0];
`ifdef ONCHIP_RAM_PARITY_EN
            pipe_perr_q[0] <= rq_vld_q & rd_perr;
`endif
            for (int i = 1; i < LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_dat_q[i] <= pipe_dat_q[i-1];
`ifdef ONCHIP_RAM_PARITY_EN
                pipe_perr_q[i] <= pipe_perr_q[i-1];
`endif
            end
        end
    end

    assign readdata      = pipe_dat_q[LAT-1];
    assign readdatavalid = pipe_vld_q[LAT-1];
`ifdef ONCHIP_RAM_PARITY_EN
    assign parity_err    = pipe_perr_q[LAT-1] & pipe_vld_q[LAT-1];
`endif

endmodule

// File: tb/tb_onchip_ram_pipe.sv
module tb_onchip_ram_pipe;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int RL     = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              clken;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              waitrequest;
    logic              clear_busy;
`ifdef ONCHIP_RAM_PARITY_EN
    logic              parity_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onchip_ram_pipe #(
        .DATA_W        (DATA_W),
        .ADDR_W        (ADDR_W),
        .READ_LATENCY  (RL),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .byteenable   (byteenable),
        .chipselect   (chipselect),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .clken        (clken),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .waitrequest  (waitrequest),
        .clear_busy   (clear_busy)
`ifdef ONCHIP_RAM_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    typedef struct {
        bit        wr;
        bit [3:0]  addr;
        bit [3:0]  be;
        bit [31:0] wdat;
        bit [31:0] exp;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge with the bus idle.
    task automatic do_write(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        address = a; byteenable = be; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    // Issues one read and waits (bounded) for its return; also checks latency.
    task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic perr);
        int n;
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        n = 0;
        while (!readdatavalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("read_latency", 64'(n), 64'(RL));
        d    = readdata;
        perr = 1'b0;
`ifdef ONCHIP_RAM_PARITY_EN
        perr = parity_err;
`endif
    endtask

    // Counts waitrequest-high cycles starting at the current negedge.
    task automatic count_clear(output int cnt, output bit saw_rdv);
        cnt = 0;
        saw_rdv = 1'b0;
        while (waitrequest && cnt < 100) begin
            if (readdatavalid) saw_rdv = 1'b1;
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        perr;
        int          cnt;
        bit          saw;

        vecs[0]  = '{1'b1, 4'd3,  4'b1111, 32'h11223344, 32'h0};
        vecs[1]  = '{1'b1, 4'd3,  4'b0101, 32'hAABBCCDD, 32'h0};
        vecs[2]  = '{1'b0, 4'd3,  4'b0000, 32'h0,        32'h11BB33DD};
        vecs[3]  = '{1'b1, 4'd4,  4'b1010, 32'hCAFEF00D, 32'h0};
        vecs[4]  = '{1'b0, 4'd4,  4'b0000, 32'h0,        32'hCA00F000};
        vecs[5]  = '{1'b1, 4'd5,  4'b1111, 32'h12345678, 32'h0};
        vecs[6]  = '{1'b0, 4'd5,  4'b0000, 32'h0,        32'h12345678};
        vecs[7]  = '{1'b1, 4'd5,  4'b0000, 32'hFFFFFFFF, 32'h0};
        vecs[8]  = '{1'b0, 4'd5,  4'b0000, 32'h0,        32'h12345678};
        vecs[9]  = '{1'b1, 4'd15, 4'b1000, 32'hA5FFFFFF, 32'h0};
        vecs[10] = '{1'b0, 4'd15, 4'b0000, 32'h0,        32'hA5000000};
        vecs[11] = '{1'b1, 4'd0,  4'b1111, 32'hFFFFFFFF, 32'h0};
        vecs[12] = '{1'b0, 4'd0,  4'b0000, 32'h0,        32'hFFFFFFFF};
        vecs[13] = '{1'b0, 4'd3,  4'b0000, 32'h0,        32'h11BB33DD};
        vecs[14] = '{1'b1, 4'd6,  4'b0010, 32'h0000BE00, 32'h0};

        reset_n = 1'b0; clken = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; byteenable = '0; writedata = '0;

        // ---- reset state and zero-fill over a dirty array ----
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) dut.mem[i] = '1;
        for (int i = 0; i < 16; i++) dut.mem[i][31:0] = 32'hDEADBEEF;
        check("rst_readdata", 64'(readdata), 64'h0);
        check("rst_rdv", 64'(readdatavalid), 64'h0);
        check("rst_waitreq", 64'(waitrequest), 64'h1);
        check("rst_clear_busy", 64'(clear_busy), 64'h1);
        @(negedge clk);
        reset_n = 1'b1;
        count_clear(cnt, saw);
        check("clear_cycles", 64'(cnt), 64'd16);
        check("clear_busy_done", 64'(clear_busy), 64'h0);
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i), d, perr);
            check("clear_read", 64'(d), 64'h0);
        end

        // ---- table-driven writes/reads ----
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].be, vecs[i].wdat);
            end else begin
                do_read(vecs[i].addr, d, perr);
                check("vec_read", 64'(d), 64'(vecs[i].exp));
            end
        end
        do_read(4'd6, d, perr);
        check("vec_read_lane1", 64'(d), 64'h0000BE00);

        // ---- read and write together: write wins, read dropped ----
        chipselect = 1'b1; read = 1'b1; write = 1'b1;
        address = 4'd9; byteenable = 4'hF; writedata = 32'h55AA55AA;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (readdatavalid) saw = 1'b1;
            @(negedge clk);
        end
        check("rw_no_rdv", 64'(saw), 64'h0);
        do_read(4'd9, d, perr);
        check("rw_write_done", 64'(d), 64'h55AA55AA);

        // ---- back-to-back reads, addresses 0..7 hold their own index ----
        for (int i = 0; i < 8; i++) do_write(4'(i), 4'hF, 32'(i));
        for (int j = 0; j < 12; j++) begin
            if (j >= 1) begin
                int k;
                bit ev;
                k  = j - 1;
                ev = (k >= 2 && k <= 9);
                check("b2b_rdv", 64'(readdatavalid), 64'(ev));
                if (ev) check("b2b_data", 64'(readdata), 64'(k - 2));
            end
            if (j < 8) begin
                chipselect = 1'b1; read = 1'b1; address = 4'(j);
            end else begin
                chipselect = 1'b0; read = 1'b0;
            end
            @(negedge clk);
        end

        // ---- clken stall with two reads in flight ----
        chipselect = 1'b1; read = 1'b1; address = 4'd2;
        @(negedge clk);
        address = 4'd5;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0; clken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_waitreq", 64'(waitrequest), 64'h1);
            check("stall_no_rdv", 64'(readdatavalid), 64'h0);
            @(negedge clk);
        end
        clken = 1'b1;
        @(negedge clk);
        check("stall_rdv_a", 64'(readdatavalid), 64'h1);
        check("stall_data_a", 64'(readdata), 64'h2);
        @(negedge clk);
        check("stall_rdv_b", 64'(readdatavalid), 64'h1);
        check("stall_data_b", 64'(readdata), 64'h5);
        @(negedge clk);
        check("stall_rdv_end", 64'(readdatavalid), 64'h0);

`ifdef ONCHIP_RAM_PARITY_EN
        // ---- parity error detection ----
        do_write(4'd10, 4'hF, 32'h000000FF);
        dut.mem[10][0] = ~dut.mem[10][0];
        do_read(4'd10, d, perr);
        check("par_data", 64'(d), 64'h000000FE);
        check("par_err", 64'(perr), 64'h1);
        do_read(4'd3, d, perr);
        check("par_clean", 64'(perr), 64'h0);
`endif

        // ---- reset one cycle after a read is accepted ----
        chipselect = 1'b1; read = 1'b1; address = 4'd3;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0; reset_n = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (readdatavalid) saw = 1'b1;
            @(negedge clk);
        end
        check("mid_rst_clear_busy", 64'(clear_busy), 64'h1);
        reset_n = 1'b1;
        count_clear(cnt, saw);
        check("mid_rst_no_rdv", 64'(saw), 64'h0);
        check("mid_rst_clear_cycles", 64'(cnt), 64'd16);
        do_read(4'd3, d, perr);
        check("mid_rst_cleared", 64'(d), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/onchip_ram_pipe.md
# onchip_ram_pipe

Parametrised single-port on-chip RAM behind a pipelined Avalon-MM slave, the successor to the fixed 512×32 unregistered-output Nios on-chip memory. Adds configurable data width/depth, 1- or 2-cycle read latency with `readdatavalid`, `waitrequest` flow control, and a hardware zero-fill engine that clears the array after reset. It sits on the Nios data/instruction bus as scratch or boot RAM.

## Interface
Parameters:
- `DATA_W`, 32, data width in bits; multiple of 8, range 8–64.
- `ADDR_W`, 9, word-address width; depth = 2^`ADDR_W` words.
- `READ_LATENCY`, 1, cycles from read acceptance to `readdatavalid`; only 1 or 2 are legal.
- `CLEAR_ON_RESET`, 1, 1 = zero-fill the whole array after reset; 0 = skip the fill; contents are undefined until written.

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in `ADDR_W`: word address.
- `byteenable` in `DATA_W/8`: write byte lanes.
- `chipselect` in 1: slave select.
- `read` in 1: read request.
- `write` in 1: write request.
- `writedata` in `DATA_W`: write data.
- `clken` in 1: clock enable; when low, the whole block holds its state.
- `readdata` out `DATA_W`: read data; valid only while `readdatavalid` is high.
- `readdatavalid` out 1: one-cycle pulse per accepted read.
- `waitrequest` out 1: high means no request is accepted this cycle.
- `clear_busy` out 1: high while the zero-fill is running.

## Operation
- **FSM states:** `CLEAR` and `RUN`.
  - On reset, the FSM enters `CLEAR` if `CLEAR_ON_RESET`=1, otherwise `RUN`.
- **`CLEAR` state:**
  - An `ADDR_W`-bit counter starts at 0.
  - Each `clken` cycle writes all-zero data with all byte lanes enabled at the counter address, then increments the counter.
  - When the counter equals 2^`ADDR_W`−1, that write completes and the FSM moves to `RUN` on the next edge.
  - `clear_busy` is 1 during `CLEAR` and 0 in `RUN`.
- **Handshake:**
  - `waitrequest` = `CLEAR` | ~`clken`.
  - A request is accepted when `chipselect` & (`read`|`write`) & ~`waitrequest`.
  - Masters hold the request stable while `waitrequest` is high.
- **Write:** an accepted write updates only the lanes whose `byteenable` bit is 1.
- **Read:**
  - An accepted read enters a valid/data shift pipeline of depth `READ_LATENCY`.
  - Reads are fully pipelined: one read per cycle is accepted, with no limit on outstanding reads.
- **`read` and `write` high together:** the write is performed, the read is dropped and produces no `readdatavalid`.
- **Read-after-write to the same address (next cycle):** returns the new data.
- **`clken` low:**
  - No array access takes place.
  - The pipeline, FSM and clear counter all freeze.
  - A `readdatavalid` that is high stays high until `clken` returns.
- **Reset mid-operation:** outstanding reads are discarded (no `readdatavalid`), the clear counter returns to 0 and the fill restarts.

## Timing
- **Reset values:**
  - `readdata`=0, `readdatavalid`=0.
  - `waitrequest`=1.
  - `clear_busy`=`CLEAR_ON_RESET`.
  - Clear counter=0.
- **Read latency:** a read accepted at edge N gives `readdatavalid` and `readdata` high/valid after edge N+`READ_LATENCY`, assuming `clken` is continuously high.
- **Clear duration:** 2^`ADDR_W` `clken`-high cycles. `waitrequest` falls on the first cycle after the last clear write.
- **Throughput:** one access per cycle in `RUN`.

## Configuration
- **`ONCHIP_RAM_PARITY_EN` defined:**
  - The array stores one even-parity bit per byte lane; each written lane's parity bit is updated with it.
  - Zero-fill writes parity 0.
  - An extra output, `parity_err` (1 bit, reset 0), pulses with `readdatavalid` when any lane's stored parity mismatches its data.
  - `readdata` is unaffected by a parity error.
- **`ONCHIP_RAM_PARITY_EN` undefined:** no parity storage, no `parity_err` port.

## Test plan
- **Reset clear:** reset with `ADDR_W`=4, `CLEAR_ON_RESET`=1 after pre-loading 0xDEADBEEF everywhere via backdoor -> `waitrequest` high exactly 16 cycles; every subsequent read returns 0x00000000.
- **Byte-enable write:** write 0x11223344 with `byteenable`=4'b1111, then 0xAABBCCDD with `byteenable`=4'b0101 to address 3, then read address 3 -> 0x11BB33DD.
- **Back-to-back reads:** `READ_LATENCY`=2, 8 reads on consecutive cycles to addresses 0..7 holding value=address -> `readdatavalid` high for 8 consecutive cycles starting at edge N+2, data 0..7 in order.
- **`clken` stall:** drop `clken` for 3 cycles while 2 reads are in flight -> `waitrequest` high throughout; data still delivered in order; total delay extended by exactly 3 cycles.
- **Reset mid-read:** assert `reset_n`=0 one cycle after a read is accepted -> no `readdatavalid` appears; the clear restarts from address 0.
- **Parity (with `ONCHIP_RAM_PARITY_EN`):** write 0x000000FF, flip data bit 0 via backdoor, read -> `parity_err`=1 in the same cycle as `readdatavalid`; a clean read gives `parity_err`=0.
